// File: rtl/cache_wrapper_if.sv
// CPU request/response and main-memory handshake bundle for cache_wrapper.
// slave = cache side, master = core/memory side (testbench or integration glue).
interface cache_wrapper_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_valid_i;
    logic                  cpu_ready_o;
    logic                  cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_adr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  cpu_resp_valid_o;
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_adr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  cpu_valid_i, cpu_we_i, cpu_adr_i, cpu_wdata_i, mem_ready_i, mem_rdata_i,
        output cpu_ready_o, cpu_rdata_o, cpu_resp_valid_o,
        output mem_valid_o, mem_we_o, mem_adr_o, mem_wdata_o
    );

    modport master (
        output cpu_valid_i, cpu_we_i, cpu_adr_i, cpu_wdata_i, mem_ready_i, mem_rdata_i,
        input  cpu_ready_o, cpu_rdata_o, cpu_resp_valid_o,
        input  mem_valid_o, mem_we_o, mem_adr_o, mem_wdata_o
    );
endinterface

// File: rtl/cache_wrapper.sv
// Direct-mapped, write-through, write-allocate single-word-line cache.
// Define CACHE_STATS_EN to add 32-bit read hit/miss counters.
module cache_wrapper #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cache_wrapper_if.slave       bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
`endif
);
    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

    logic [INDEX_W-1:0]    req_idx, cur_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  req_hit;
    logic                  fill;
    logic [DATA_WIDTH-1:0] fill_data;

    assign req_idx = bus.cpu_adr_i[INDEX_W-1:0];
    assign req_tag = bus.cpu_adr_i[ADDR_WIDTH-1:INDEX_W];
    assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cur_idx = adr_q[INDEX_W-1:0];

    assign bus.cpu_ready_o      = rst_ni && (state_q == S_IDLE);
    assign bus.cpu_rdata_o      = rdata_q;
    assign bus.cpu_resp_valid_o = resp_q;
    assign bus.mem_valid_o      = mem_valid_q;
    assign bus.mem_we_o         = mem_we_q;
    assign bus.mem_adr_o        = mem_adr_q;
    assign bus.mem_wdata_o      = mem_wdata_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = 1'b0;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        fill        = 1'b0;
        fill_data   = we_q ? wdata_q : bus.mem_rdata_i;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_valid_i) begin
                    adr_d   = bus.cpu_adr_i;
                    we_d    = bus.cpu_we_i;
                    wdata_d = bus.cpu_wdata_i;
                    if (!bus.cpu_we_i && req_hit) begin
                        rdata_d = data_mem[req_idx];
                        resp_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_we_d    = bus.cpu_we_i;
                        mem_adr_d   = bus.cpu_adr_i;
                        if (bus.cpu_we_i) begin
                            mem_wdata_d = bus.cpu_wdata_i;
                        end
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM: begin
                if (bus.mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    fill        = 1'b1;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata_i;
                    end
                    resp_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Valid bits are the only line state that needs reset; tag/data are gated by them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[cur_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_mem[cur_idx]  <= adr_q[ADDR_WIDTH-1:INDEX_W];
            data_mem[cur_idx] <= fill_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        rd_accept;

    assign rd_accept    = (state_q == S_IDLE) && bus.cpu_valid_i && !bus.cpu_we_i;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rd_accept) begin
            if (req_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else         miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_wrapper.sv
// Directed self-checking bench for cache_wrapper with a behavioural main-memory responder.
module tb_cache_wrapper;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_wrapper_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_wrapper #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_LINES(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_o  (hit_cnt),
        .miss_count_o (miss_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_model [0:65535];
    int          req_cnt   = 0;
    int          ready_cyc = -1;
    int          wait_cnt  = 0;
    int          mem_lat   = 2;
    bit          mem_hold  = 1'b0;
    logic        last_we   = 1'b0;
    logic [15:0] last_adr  = '0;
    logic [31:0] last_wdata = '0;

    // Memory responder: pulses mem_ready_i mem_lat cycles after seeing a request
    initial begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready_i = 1'b0;
            if (bus.mem_valid_o && !mem_hold) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    wait_cnt   = 0;
                    req_cnt++;
                    ready_cyc  = cyc;
                    last_we    = bus.mem_we_o;
                    last_adr   = bus.mem_adr_o;
                    last_wdata = bus.mem_wdata_o;
                    bus.mem_rdata_i = mem_model[bus.mem_adr_o];
                    if (bus.mem_we_o) mem_model[bus.mem_adr_o] = bus.mem_wdata_o;
                    bus.mem_ready_i = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                              output logic [31:0] rd, output int n, output int resp_cyc,
                              output logic pulse_after);
        bus.cpu_valid_i = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_adr_i   = adr;
        bus.cpu_wdata_i = wd;
        n        = 0;
        resp_cyc = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus.cpu_valid_i = 1'b0;
            if (bus.cpu_resp_valid_o) begin
                n        = i;
                resp_cyc = cyc;
                break;
            end
        end
        rd = bus.cpu_rdata_o;
        @(posedge clk);
        #1;
        pulse_after = bus.cpu_resp_valid_o;
    endtask

    // Access that must go to memory (read miss or any write)
    task automatic do_mem(input string name, input logic we, input logic [15:0] adr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        logic [31:0] rd;
        int          n, rc, pre;
        logic        pa;
        pre = req_cnt;
        cpu_access(we, adr, wd, rd, n, rc, pa);
        chk({name, "_memreq"}, 32'(req_cnt), 32'(pre + 1));
        chk({name, "_memadr"}, 32'(last_adr), 32'(adr));
        chk({name, "_memwe"},  32'(last_we), 32'(we));
        if (we) chk({name, "_memwdata"}, last_wdata, wd);
        chk({name, "_resp_lat"}, 32'(rc), 32'(ready_cyc + 1));
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_pulse1"}, 32'(pa), 32'd0);
    endtask

    task automatic do_hit(input string name, input logic [15:0] adr, input logic [31:0] exp_rd);
        logic [31:0] rd;
        int          n, rc, pre;
        logic        pa;
        pre = req_cnt;
        cpu_access(1'b0, adr, 32'd0, rd, n, rc, pa);
        chk({name, "_lat"}, 32'(n), 32'd1);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_nomem"}, 32'(req_cnt), 32'(pre));
        chk({name, "_pulse1"}, 32'(pa), 32'd0);
    endtask

    initial begin
        logic seen_resp;
        bus.cpu_valid_i = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_adr_i   = '0;
        bus.cpu_wdata_i = '0;
        mem_model[16'h0010] = 32'h1111_2222;
        mem_model[16'h0030] = 32'h1234_5678;
        mem_model[16'h0050] = 32'hCAFE_F00D;
        mem_model[16'h0070] = 32'h7777_0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.cpu_ready_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_after", 32'(bus.cpu_ready_o), 32'd1);
        chk("rst_resp", 32'(bus.cpu_resp_valid_o), 32'd0);
        chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
        chk("rst_memvalid", 32'(bus.mem_valid_o), 32'd0);
        chk("rst_memwe", 32'(bus.mem_we_o), 32'd0);
        chk("rst_memadr", 32'(bus.mem_adr_o), 32'd0);
        chk("rst_memwdata", bus.mem_wdata_o, 32'd0);

        do_mem("rd10_miss", 1'b0, 16'h0010, 32'd0, 32'h1111_2222);
        do_mem("wr10", 1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h1111_2222);
        chk("wr10_memmodel", mem_model[16'h0010], 32'hDEAD_BEEF);
        do_mem("wr20", 1'b1, 16'h0020, 32'hBEEF_DEAD, 32'h1111_2222);
        do_hit("rd10_hit", 16'h0010, 32'hDEAD_BEEF);
        do_hit("rd20_hit", 16'h0020, 32'hBEEF_DEAD);
        do_mem("rd30_miss", 1'b0, 16'h0030, 32'd0, 32'h1234_5678);
        do_hit("rd30_hit", 16'h0030, 32'h1234_5678);
        do_mem("wr10_again", 1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h1234_5678);
        do_mem("rd50_conflict", 1'b0, 16'h0050, 32'd0, 32'hCAFE_F00D);
        do_mem("rd10_evicted", 1'b0, 16'h0010, 32'd0, 32'hDEAD_BEEF);
`ifdef CACHE_STATS_EN
        chk("stats_hits", hit_cnt, 32'd3);
        chk("stats_misses", miss_cnt, 32'd4);
`endif

        // Abort a miss while the memory is stalled
        mem_hold = 1'b1;
        bus.cpu_valid_i = 1'b1;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_adr_i   = 16'h0070;
        @(posedge clk);
        #1;
        bus.cpu_valid_i = 1'b0;
        chk("abort_memvalid_pre", 32'(bus.mem_valid_o), 32'd1);
        chk("abort_memadr_pre", 32'(bus.mem_adr_o), 32'h0070);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_memvalid", 32'(bus.mem_valid_o), 32'd0);
        chk("abort_ready", 32'(bus.cpu_ready_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        seen_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.cpu_resp_valid_o || bus.mem_valid_o) seen_resp = 1'b1;
        end
        chk("abort_no_resp", 32'(seen_resp), 32'd0);
`ifdef CACHE_STATS_EN
        chk("abort_stats_hits", hit_cnt, 32'd0);
        chk("abort_stats_misses", miss_cnt, 32'd0);
`endif
        do_mem("rd20_after_rst", 1'b0, 16'h0020, 32'd0, 32'hBEEF_DEAD);
        do_mem("rd30_after_rst", 1'b0, 16'h0030, 32'd0, 32'h1234_5678);
        do_hit("rd20_rehit", 16'h0020, 32'hBEEF_DEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
